imem_loader: RTL
================

# imem_loader

Boot-time program loader placed directly upstream of the 16-bit single-cycle MIPS core (`mips_16`). It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from address 0. It zero-fills the unused tail and holds the core in reset for a programmable number of cycles. It then releases the core so execution starts at PC 0. The same block replaces the fixed 100 ns reset pulse used in simulation, and supports reloading a new program at run time.

## Interface
Parameters:
- `ADDR_W`, 8: instruction memory address width. Depth = 2^ADDR_W words.
- `DATA_W`, 16: instruction word width.
- `HOLD_CYCLES`, 4: cycles the core stays in reset after loading completes. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load. Honoured in IDLE, RUN and ERR; ignored in LOAD, FILL and HOLD.
- `in_valid`  in  1  the current stream word is valid.
- `in_data`  in  DATA_W  instruction word.
- `in_last`  in  1  the current word is the final program word.
- `in_ready`  out  1  loader accepts a word this cycle. Combinational: `state==LOAD`.
- `imem_we`  out  1  instruction memory write enable. Registered.
- `imem_addr`  out  ADDR_W  write address. Registered.
- `imem_wdata`  out  DATA_W  write data. Registered.
- `cpu_reset`  out  1  active-high reset to `mips_16`. Registered.
- `done`  out  1  program loaded and core running.
- `error`  out  1  program exceeded the memory depth.
- `word_count`  out  ADDR_W+1  number of program words accepted in the last load.

## Operation
- States: IDLE, LOAD, FILL, HOLD, RUN, ERR.
- Reset values, applied asynchronously:
  - state IDLE
  - `cpu_reset`=1
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `done`=0, `error`=0, `word_count`=0
  - internal write pointer 0, hold counter 0
- IDLE → LOAD on `start`. On entry to LOAD: write pointer=0, `word_count`=0, `error`=0, `done`=0, `cpu_reset`=1.
- LOAD: a handshake occurs when `in_valid && in_ready`. Each handshake:
  - writes `in_data` at the pointer
  - increments the pointer and `word_count`
- LOAD exits on the handshake cycle, checked in this order:
  - `in_last`=1: if the pointer was 2^ADDR_W−1, go to HOLD; otherwise go to FILL.
  - `in_last`=0 at pointer 2^ADDR_W−1: the word is still written, then go to ERR. Further words are not accepted.
- FILL: writes 0 (NOP) at the pointer once per cycle, with no handshake. After writing address 2^ADDR_W−1, go to HOLD.
- HOLD: `cpu_reset` stays 1 for HOLD_CYCLES cycles, then go to RUN.
- RUN: `cpu_reset`=0, `done`=1. On `start`, go to LOAD; `cpu_reset` returns to 1 on the next edge.
- ERR: `cpu_reset`=1, `error`=1, `done`=0. Leaves only on `start`, to LOAD.
- `word_count` saturates at 2^ADDR_W and is held until the next `start`.
- Asserting `reset_n` low at any point, including mid-LOAD or mid-FILL, immediately restores all reset values. Partially written memory is not cleared.

## Timing
- Write latency: a handshake in cycle N produces `imem_we`=1 with the matching addr/data in cycle N+1.
- Back-to-back handshakes give one write per cycle.
- `in_ready` drops in the cycle after the `in_last` handshake.
- FILL for a program of K words (K < depth) lasts 2^ADDR_W−K cycles.
- The `cpu_reset` falling edge comes HOLD_CYCLES+1 cycles after the last memory write.
- `done` rises in the same cycle that `cpu_reset` falls.
- `start` in RUN: `cpu_reset`=1 and `in_ready`=1 are both visible one cycle later.

## Structure
- Shared package `imem_loader_pkg`: the state encoding (IDLE=0, LOAD=1, FILL=2, HOLD=3, RUN=4, ERR=5) and the NOP constant 16'h0000.
- One natural sub-module: `hold_counter`, a loadable down-counter that generates the HOLD-to-RUN release. All other logic stays flat.

## Test plan
- Load 3 words (0x1111, 0x2222, 0x3333 with `in_last`), ADDR_W=4:
  - writes at addresses 0–2 with those values
  - zeros written at addresses 3–15
  - `word_count`=3
  - `cpu_reset` falls 5 cycles after the write to address 15; `done`=1
- Drop `in_valid` for 2 cycles mid-stream: no write issued during the gap, and addresses stay contiguous.
- Send 16 words, the last with `in_last`, ADDR_W=4: FILL is skipped and the core goes straight to HOLD.
- Send 16 words with no `in_last`, ADDR_W=4:
  - `error`=1, `cpu_reset` stays 1, `in_ready`=0
  - a subsequent `start` clears `error`
- Pulse `start` in RUN: `cpu_reset`=1 on the next cycle, a second load proceeds, and `word_count` reflects the new program.
- Drive `reset_n` low mid-FILL: all outputs return to their reset values asynchronously, and the FSM stays in IDLE until `start`.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
// State encoding and the NOP word written into the unused memory tail.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_HOLD = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/imem_loader_hold_counter.sv
// Loadable down-counter that times how long the core is kept in reset
// after loading; zero marks the cycle in which the release may happen.
module hold_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: streams words into instruction memory from
// address 0, zero-fills the tail, then releases the core from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W:0]   wc_d;
  logic              we_d, cpu_reset_d, done_d, error_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              hold_load, hold_zero, handshake;

  assign in_ready  = (state == ST_LOAD);
  assign handshake = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      word_count <= wc_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_reset  <= cpu_reset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // All registered outputs are computed here so each has a single next value.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    wc_d        = word_count;
    we_d        = 1'b0;
    addr_d      = imem_addr;
    wdata_d     = imem_wdata;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;
    hold_load   = 1'b0;

    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d     = ST_LOAD;
          ptr_d       = '0;
          wc_d        = '0;
          error_d     = 1'b0;
          done_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          we_d    = 1'b1;
          addr_d  = ptr;
          wdata_d = in_data;
          ptr_d   = ptr + ADDR_W'(1);
          if (word_count != WC_MAX) begin
            wc_d = word_count + (ADDR_W+1)'(1);
          end
          // A final word landing in the top slot leaves nothing to zero-fill.
          if (in_last) begin
            if (ptr == PTR_MAX) begin
              state_d   = ST_HOLD;
              hold_load = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end else if (ptr == PTR_MAX) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        we_d    = 1'b1;
        addr_d  = ptr;
        wdata_d = DATA_W'(NOP_WORD);
        ptr_d   = ptr + ADDR_W'(1);
        if (ptr == PTR_MAX) begin
          state_d   = ST_HOLD;
          hold_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_zero) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  hold_counter #(
    .CNT_W(CNT_W)
  ) u_hold_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (hold_load),
    .load_value (CNT_W'(HOLD_CYCLES)),
    .enable     (state == ST_HOLD),
    .zero       (hold_zero)
  );

endmodule
